// File: rtl/corelet_ctrl_if.sv
// Host/corelet-side bundle for the corelet sequencing controller.
// The controller owns the master view; the host/corelet side uses slave.
interface corelet_ctrl_if #(
  parameter int xaddr_bw = 11,
  parameter int paddr_bw = 11,
  parameter int len_bw   = 8
);
  logic                start;
  logic [len_bw-1:0]   len_x;
  logic [xaddr_bw-1:0] x_base;
  logic                l0_full;
  logic                l0_ready;
  logic                ofifo_valid;
  logic [33:0]         inst_q;
  logic                xmem_cen;
  logic [xaddr_bw-1:0] xmem_addr;
  logic                pmem_wen;
  logic [paddr_bw-1:0] pmem_addr;
  logic                busy;
  logic                done;

  modport master (
    input  start, len_x, x_base,
    input  l0_full, l0_ready, ofifo_valid,
    output inst_q, xmem_cen, xmem_addr,
    output pmem_wen, pmem_addr, busy, done
  );

  modport slave (
    output start, len_x, x_base,
    output l0_full, l0_ready, ofifo_valid,
    input  inst_q, xmem_cen, xmem_addr,
    input  pmem_wen, pmem_addr, busy, done
  );
endinterface

// File: rtl/corelet_ctrl.sv
// Corelet tile sequencer: weight fill/load, flush, activation
// fill/execute, and OFIFO drain into pmem. All outputs registered.
module corelet_ctrl #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int xaddr_bw = 11,
  parameter int paddr_bw = 11,
  parameter int len_bw   = 8
) (
  input logic clk,
  input logic reset,
  corelet_ctrl_if.master bus_io
);

  localparam int CW = 16;
  localparam logic [CW-1:0] COLS    = CW'(col);
  localparam logic [CW-1:0] FL_LAST = CW'(row + col - 1);
  localparam logic [CW-1:0] C1      = CW'(1);
  localparam logic [xaddr_bw-1:0] X1 = xaddr_bw'(1);
  localparam logic [paddr_bw-1:0] P1 = paddr_bw'(1);

  typedef enum logic [2:0] {
    IDLE, W_FILL, W_LOAD, W_FLUSH,
    X_FILL, X_EXEC, DRAIN, DONE
  } state_e;

  state_e              st_q;
  logic [CW-1:0]       iss_q;
  logic [CW-1:0]       cmp_q;
  logic                pend_q;
  logic [len_bw-1:0]   len_q;
  logic [xaddr_bw-1:0] rd_ptr_q;
  logic [paddr_bw-1:0] pa_q;

  logic [33:0]         inst_q_q;
  logic                xcen_q;
  logic [xaddr_bw-1:0] xaddr_q;
  logic                pwen_q;
  logic [paddr_bw-1:0] paddr_q;
  logic                busy_q;
  logic                done_q;

  logic [CW-1:0] tgt;
  logic [CW-1:0] cmp_inc;

  // Weight phases count col vectors; activation phases count len_x.
  assign tgt = (st_q == W_FILL || st_q == W_LOAD) ? COLS : CW'(len_q);
  assign cmp_inc = cmp_q + C1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= IDLE;
      iss_q    <= '0;
      cmp_q    <= '0;
      pend_q   <= 1'b0;
      len_q    <= '0;
      rd_ptr_q <= '0;
      pa_q     <= '0;
      inst_q_q <= '0;
      xcen_q   <= 1'b1;
      xaddr_q  <= '0;
      pwen_q   <= 1'b1;
      paddr_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      inst_q_q <= '0;
      xcen_q   <= 1'b1;
      pwen_q   <= 1'b1;
      done_q   <= 1'b0;
      unique case (st_q)
        IDLE: begin
          if (bus_io.start) begin
            len_q    <= bus_io.len_x;
            rd_ptr_q <= bus_io.x_base;
            pa_q     <= '0;
            iss_q    <= '0;
            cmp_q    <= '0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b1;
            st_q     <= W_FILL;
          end
        end
        W_FILL, X_FILL: begin
          // xmem has one cycle of read latency: write L0 the cycle after
          if (pend_q) begin
            inst_q_q[2] <= 1'b1;
            pend_q      <= 1'b0;
            if (cmp_inc == tgt) begin
              cmp_q <= '0;
              iss_q <= '0;
              st_q  <= (st_q == W_FILL) ? W_LOAD : X_EXEC;
            end else begin
              cmp_q <= cmp_inc;
            end
          end else if (!bus_io.l0_full && iss_q < tgt) begin
            xcen_q   <= 1'b0;
            xaddr_q  <= rd_ptr_q;
            rd_ptr_q <= rd_ptr_q + X1;
            iss_q    <= iss_q + C1;
            pend_q   <= 1'b1;
          end
        end
        W_LOAD, X_EXEC: begin
          if (bus_io.l0_ready) begin
            inst_q_q[3] <= 1'b1;
            inst_q_q[0] <= (st_q == W_LOAD);
            inst_q_q[1] <= (st_q == X_EXEC);
            if (cmp_inc == tgt) begin
              cmp_q <= '0;
              st_q  <= (st_q == W_LOAD) ? W_FLUSH : DRAIN;
            end else begin
              cmp_q <= cmp_inc;
            end
          end
        end
        W_FLUSH: begin
          if (cmp_q == FL_LAST) begin
            cmp_q <= '0;
            if (len_q == '0) begin
              st_q   <= DONE;
              done_q <= 1'b1;
            end else begin
              st_q <= X_FILL;
            end
          end else begin
            cmp_q <= cmp_inc;
          end
        end
        DRAIN: begin
          pend_q <= 1'b0;
          if (bus_io.ofifo_valid && iss_q < tgt) begin
            inst_q_q[6] <= 1'b1;
            iss_q       <= iss_q + C1;
            pend_q      <= 1'b1;
          end
          if (pend_q) begin
            pwen_q  <= 1'b0;
            paddr_q <= pa_q;
            pa_q    <= pa_q + P1;
            cmp_q   <= cmp_inc;
            if (cmp_inc == tgt) begin
              st_q   <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          st_q   <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign bus_io.inst_q    = inst_q_q;
  assign bus_io.xmem_cen  = xcen_q;
  assign bus_io.xmem_addr = xaddr_q;
  assign bus_io.pmem_wen  = pwen_q;
  assign bus_io.pmem_addr = paddr_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: tile vector table plus
// backpressure, sparse-ready, start-while-busy and reset sequences.
module tb_corelet_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  corelet_ctrl_if #(.xaddr_bw(11), .paddr_bw(11), .len_bw(8)) bus ();

  corelet_ctrl #(
    .row(8), .col(8), .xaddr_bw(11), .paddr_bw(11), .len_bw(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_io(bus)
  );

  typedef struct {
    int len;
    int base;
    int reads;
    int w2;
    int ld;
    int ex;
    int rd6;
    int pw;
    int first_x;
    int last_x;
    int last_p;
    int gap;
  } vec_t;

  vec_t tbl[4];

  int n_cmp = 0;
  int n_bad = 0;

  int cyc, reads, w2, ld, ex, of6, pw, dn, viol, consec;
  int first_x, last_x, last_p, ld_cyc, gap;
  bit gap_arm, ex_prev;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic clr();
    reads = 0; w2 = 0; ld = 0; ex = 0; of6 = 0; pw = 0; dn = 0;
    viol = 0; consec = 0; first_x = -1; last_x = -1; last_p = -1;
    ld_cyc = 0; gap = -1; gap_arm = 0; ex_prev = 0;
  endtask

  // Inputs are re-driven only after this runs, so the input values seen
  // here are the ones the DUT sampled on the edge that made these outputs.
  task automatic sample();
    logic [10:0] nx;
    cyc++;
    if (!bus.xmem_cen) begin
      nx = 11'(last_x + 1);
      if (reads == 0) first_x = int'(bus.xmem_addr);
      else if (bus.xmem_addr != nx) viol++;
      last_x = int'(bus.xmem_addr);
      reads++;
      if (gap_arm) begin gap = cyc - ld_cyc; gap_arm = 0; end
    end
    if (bus.inst_q[2]) begin w2++; if (bus.l0_full) viol++; end
    if (bus.inst_q[0]) begin ld++; ld_cyc = cyc; gap_arm = 1; end
    if (bus.inst_q[1]) begin ex++; if (ex_prev) consec++; end
    ex_prev = bus.inst_q[1];
    if (bus.inst_q[3] && !bus.l0_ready) viol++;
    if ((bus.inst_q[0] | bus.inst_q[1]) != bus.inst_q[3]) viol++;
    if (bus.inst_q[0] && bus.inst_q[1]) viol++;
    if (bus.inst_q[6]) begin of6++; if (!bus.ofifo_valid) viol++; end
    if ((bus.inst_q & ~34'h4F) != '0) viol++;
    if (!bus.pmem_wen) begin
      if (int'(bus.pmem_addr) != pw) viol++;
      last_p = int'(bus.pmem_addr);
      pw++;
    end
    if (bus.done) begin
      dn++;
      if (!bus.busy) viol++;
      if (gap_arm) begin gap = cyc - ld_cyc; gap_arm = 0; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic start_tile(input int len, input int base);
    bus.start  = 1'b1;
    bus.len_x  = 8'(len);
    bus.x_base = 11'(base);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d0, n;
    d0 = dn;
    n = 0;
    while (dn == d0 && n < 2000) begin tick(); n++; end
    chk({nm, "_done_seen"}, dn - d0, 1);
  endtask

  initial begin
    int n;
    int r0, w0;
    tbl[0] = '{4, 'h010, 12, 12, 8, 4, 4, 4, 'h010, 'h01B, 3, 17};
    tbl[1] = '{0, 'h020,  8,  8, 8, 0, 0, 0, 'h020, 'h027, -1, 16};
    tbl[2] = '{1, 'h7FF,  9,  9, 8, 1, 1, 1, 'h7FF, 'h007, 0, 17};
    tbl[3] = '{3, 'h100, 11, 11, 8, 3, 3, 3, 'h100, 'h10A, 2, 17};

    cyc = 0;
    clr();
    reset = 1'b0;
    bus.start = 1'b0;
    bus.len_x = '0;
    bus.x_base = '0;
    bus.l0_full = 1'b0;
    bus.l0_ready = 1'b1;
    bus.ofifo_valid = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_inst",  int'(bus.inst_q != '0), 0);
    chk("rst_xcen",  int'(bus.xmem_cen), 1);
    chk("rst_pwen",  int'(bus.pmem_wen), 1);
    chk("rst_xaddr", int'(bus.xmem_addr), 0);
    chk("rst_paddr", int'(bus.pmem_addr), 0);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_done",  int'(bus.done), 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      clr();
      start_tile(tbl[i].len, tbl[i].base);
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_reads", i), reads, tbl[i].reads);
      chk($sformatf("v%0d_l0wr", i), w2, tbl[i].w2);
      chk($sformatf("v%0d_kload", i), ld, tbl[i].ld);
      chk($sformatf("v%0d_exec", i), ex, tbl[i].ex);
      chk($sformatf("v%0d_ofrd", i), of6, tbl[i].rd6);
      chk($sformatf("v%0d_pmwr", i), pw, tbl[i].pw);
      chk($sformatf("v%0d_first_x", i), first_x, tbl[i].first_x);
      chk($sformatf("v%0d_last_x", i), last_x, tbl[i].last_x);
      chk($sformatf("v%0d_last_p", i), last_p, tbl[i].last_p);
      chk($sformatf("v%0d_flush_gap", i), gap, tbl[i].gap);
      tick();
      chk($sformatf("v%0d_busy_off", i), int'(bus.busy), 0);
      chk($sformatf("v%0d_done_cnt", i), dn, 1);
      chk($sformatf("v%0d_rules", i), viol, 0);
    end

    // Backpressure: stall L0 for 5 cycles right after the 3rd weight write
    clr();
    start_tile(2, 'h10);
    n = 0;
    while (w2 < 3 && n < 100) begin tick(); n++; end
    chk("bp_reach", w2, 3);
    bus.l0_full = 1'b1;
    r0 = reads;
    w0 = w2;
    repeat (5) tick();
    chk("bp_hold_rd", reads - r0, 0);
    chk("bp_hold_wr", w2 - w0, 0);
    bus.l0_full = 1'b0;
    tick();
    chk("bp_resume_n", reads - r0, 1);
    chk("bp_resume_addr", last_x, 'h13);
    wait_done("bp");
    chk("bp_l0wr", w2, 10);
    chk("bp_kload", ld, 8);
    chk("bp_reads", reads, 10);
    chk("bp_rules", viol, 0);
    tick();

    // Sparse ready: alternate l0_ready through activation execute
    clr();
    start_tile(6, 'h200);
    n = 0;
    while (w2 < 14 && n < 300) begin tick(); n++; end
    chk("sp_reach", w2, 14);
    n = 0;
    while (ex < 6 && n < 100) begin
      bus.l0_ready = ~bus.l0_ready;
      tick();
      n++;
    end
    bus.l0_ready = 1'b1;
    wait_done("sp");
    chk("sp_exec", ex, 6);
    chk("sp_consec", consec, 0);
    chk("sp_ofrd", of6, 6);
    chk("sp_pmwr", pw, 6);
    chk("sp_rules", viol, 0);
    tick();

    // Start during DRAIN must not re-latch or restart
    clr();
    start_tile(4, 'h30);
    n = 0;
    while (of6 < 1 && n < 300) begin tick(); n++; end
    chk("sb_reach", of6, 1);
    start_tile(2, 'h50);
    wait_done("sb");
    chk("sb_ofrd", of6, 4);
    chk("sb_pmwr", pw, 4);
    chk("sb_last_p", last_p, 3);
    chk("sb_last_x", last_x, 'h3B);
    repeat (10) tick();
    chk("sb_done_cnt", dn, 1);
    chk("sb_reads", reads, 12);
    chk("sb_busy", int'(bus.busy), 0);

    // Asynchronous reset in the middle of execute
    clr();
    start_tile(4, 'h40);
    n = 0;
    while (ex < 2 && n < 300) begin tick(); n++; end
    chk("mr_reach", ex, 2);
    #2 reset = 1'b0;
    #1;
    chk("mr_inst", int'(bus.inst_q != '0), 0);
    chk("mr_xcen", int'(bus.xmem_cen), 1);
    chk("mr_pwen", int'(bus.pmem_wen), 1);
    chk("mr_busy", int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b1;
    clr();
    repeat (10) tick();
    chk("mr_idle_rd", reads, 0);
    chk("mr_idle_wr", w2, 0);
    chk("mr_no_done", dn, 0);
    chk("mr_idle_busy", int'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
